// File: rtl/program_loader_if.sv
// program_loader_if: byte stream, acknowledge and instruction-memory
// write bundle between the program loader and its surroundings.
//   rx_valid/rx_data  : received byte pulse from the UART receiver
//   tx_valid/tx_data  : acknowledge byte towards the UART transmitter
//   tx_ready          : transmitter can take the byte
//   reload            : restart pulse, honoured in DONE or ERR
//   imem_we/addr/wdata: instruction-memory word write port
//   busy/done/error   : loader status
interface program_loader_if #(
   parameter int unsigned ADDR_WIDTH = 14
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  tx_ready;
   logic                  tx_valid;
   logic [7:0]            tx_data;
   logic                  reload;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic                  busy;
   logic                  done;
   logic                  error;

   // Environment side: feeds bytes, drains the ack, sees memory writes.
   modport master (
      output rx_valid,
      output rx_data,
      output tx_ready,
      output reload,
      input  tx_valid,
      input  tx_data,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata,
      input  busy,
      input  done,
      input  error
   );

   // Loader side.
   modport slave (
      input  rx_valid,
      input  rx_data,
      input  tx_ready,
      input  reload,
      output tx_valid,
      output tx_data,
      output imem_we,
      output imem_addr,
      output imem_wdata,
      output busy,
      output done,
      output error
   );
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles a little-endian program image from UART bytes
// (4-byte length N, N words, 4-byte XOR checksum), writes the words into
// instruction memory, answers with one ack byte and releases the core.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : program_loader_if.slave (rx, tx ack, reload, imem write, status)
module program_loader #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned MAX_WORDS  = 16384,
   parameter logic [7:0]  ACK_OK     = 8'hAA,
   parameter logic [7:0]  ACK_ERR    = 8'h55
) (
   input logic             clk,
   input logic             rst,
   program_loader_if.slave bus
);

   localparam logic [31:0] LP_MAX = 32'(MAX_WORDS);
   localparam logic [ADDR_WIDTH:0] LP_ONE =
      {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_LEN  = 3'd0,
      ST_DATA = 3'd1,
      ST_SUM  = 3'd2,
      ST_ACK  = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [1:0]            r_bcnt;
   // Holds the first three bytes of the current word; the fourth byte
   // arrives live on rx_data, so the word is complete in that cycle.
   logic [23:0]           r_shift;
   logic [ADDR_WIDTH:0]   r_len;
   logic [ADDR_WIDTH:0]   r_wcnt;
   logic [31:0]           r_sum;
   logic                  r_ack_err;
   logic                  r_tx_valid;
   logic [7:0]            r_tx_data;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;

   logic        w_in_load;
   logic        w_byte;
   logic        w_last;
   logic [31:0] w_word;
   logic        w_len_big;
   logic        w_len_zero;
   logic        w_last_word;
   logic        w_tx_fire;
   logic        w_sum_ok;

   assign w_in_load   = (r_state == ST_LEN) ||
                        (r_state == ST_DATA) ||
                        (r_state == ST_SUM);
   assign w_byte      = bus.rx_valid && w_in_load;
   assign w_last      = w_byte && (r_bcnt == 2'd3);
   assign w_word      = {bus.rx_data, r_shift};
   assign w_len_big   = w_word > LP_MAX;
   assign w_len_zero  = w_word == 32'd0;
   // Word counter is one bit wider than the address, so N = 2^ADDR_WIDTH
   // still reaches its end condition without wrapping.
   assign w_last_word = (r_wcnt + LP_ONE) == r_len;
   assign w_tx_fire   = r_tx_valid && bus.tx_ready;
   assign w_sum_ok    = w_word == r_sum;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_LEN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_LEN: begin
            if (w_last) begin
               if (w_len_big) begin
                  w_state_nxt = ST_ACK;
               end else if (w_len_zero) begin
                  w_state_nxt = ST_SUM;
               end else begin
                  w_state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (w_last && w_last_word) begin
               w_state_nxt = ST_SUM;
            end
         end
         ST_SUM: begin
            if (w_last) begin
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            if (w_tx_fire) begin
               w_state_nxt = r_ack_err ? ST_ERR : ST_DONE;
            end
         end
         ST_DONE, ST_ERR: begin
            if (bus.reload) begin
               w_state_nxt = ST_LEN;
            end
         end
         default: w_state_nxt = ST_LEN;
      endcase
   end

   // Datapath: byte assembly, memory write port, checksum, ack byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bcnt     <= '0;
         r_shift    <= '0;
         r_len      <= '0;
         r_wcnt     <= '0;
         r_sum      <= '0;
         r_ack_err  <= 1'b0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_byte) begin
            r_bcnt  <= r_bcnt + 2'd1;
            r_shift <= {bus.rx_data, r_shift[23:8]};
         end
         unique case (r_state)
            ST_LEN: begin
               if (w_last) begin
                  r_len  <= w_word[ADDR_WIDTH:0];
                  r_wcnt <= '0;
                  if (w_len_big) begin
                     r_ack_err  <= 1'b1;
                     r_tx_valid <= 1'b1;
                     r_tx_data  <= ACK_ERR;
                  end
               end
            end
            ST_DATA: begin
               if (w_last) begin
                  r_we    <= 1'b1;
                  r_addr  <= r_wcnt[ADDR_WIDTH-1:0];
                  r_wdata <= w_word;
                  r_sum   <= r_sum ^ w_word;
                  r_wcnt  <= r_wcnt + LP_ONE;
               end
            end
            ST_SUM: begin
               if (w_last) begin
                  r_ack_err  <= !w_sum_ok;
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= w_sum_ok ? ACK_OK : ACK_ERR;
               end
            end
            ST_ACK: begin
               if (w_tx_fire) begin
                  r_tx_valid <= 1'b0;
               end
            end
            ST_DONE, ST_ERR: begin
               if (bus.reload) begin
                  r_bcnt    <= '0;
                  r_shift   <= '0;
                  r_len     <= '0;
                  r_wcnt    <= '0;
                  r_sum     <= '0;
                  r_ack_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.tx_valid   = r_tx_valid;
   assign bus.tx_data    = r_tx_data;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign bus.busy       = w_in_load || (r_state == ST_ACK);
   assign bus.done       = (r_state == ST_DONE);
   assign bus.error      = (r_state == ST_ERR);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader; loads small
// images, watches instruction-memory writes and the ack byte.
module tb_program_loader;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   program_loader_if #(.ADDR_WIDTH(14)) pl_if ();

   program_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (pl_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [13:0] wq_addr[$];
   logic [31:0] wq_data[$];

   always @(negedge clk) begin
      if (pl_if.imem_we === 1'b1) begin
         wq_addr.push_back(pl_if.imem_addr);
         wq_data.push_back(pl_if.imem_wdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      pl_if.rx_valid = 1'b1;
      pl_if.rx_data  = b;
      tick();
      pl_if.rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8]);
      end
   endtask

   task automatic pulse_reload();
      pl_if.reload = 1'b1;
      tick();
      pl_if.reload = 1'b0;
   endtask

   // Waits (bounded) for the ack byte; with tx_ready high the handshake
   // happens on the following edge, after which status is final.
   task automatic wait_ack(output bit seen, output logic [7:0] b);
      seen = 1'b0;
      b    = 8'h00;
      for (int i = 0; i < 50; i++) begin
         if (pl_if.tx_valid === 1'b1) begin
            seen = 1'b1;
            b    = pl_if.tx_data;
            break;
         end
         tick();
      end
      if (seen) tick();
   endtask

   task automatic test_reset();
      tests++;
      if ({pl_if.busy, pl_if.done, pl_if.error} !== 3'b100) begin
         fails++;
         $display("FAIL reset_status: got %b want 100",
                  {pl_if.busy, pl_if.done, pl_if.error});
      end
      tests++;
      if ({pl_if.tx_valid, pl_if.tx_data} !== 9'h000) begin
         fails++;
         $display("FAIL reset_tx: got %h want 000",
                  {pl_if.tx_valid, pl_if.tx_data});
      end
      tests++;
      if ({pl_if.imem_we, pl_if.imem_addr, pl_if.imem_wdata} !== 47'd0) begin
         fails++;
         $display("FAIL reset_imem: got we=%b a=%h d=%h want 0",
                  pl_if.imem_we, pl_if.imem_addr, pl_if.imem_wdata);
      end
   endtask

   task automatic test_load_ok();
      bit seen;
      logic [7:0] b;
      wq_addr.delete();
      wq_data.delete();
      pl_if.tx_ready = 1'b1;
      send_word(32'd2);
      send_word(32'h0000_0013);
      send_word(32'h00A0_0093);
      send_word(32'h00A0_0080);
      wait_ack(seen, b);
      tests++;
      if (!seen || b !== 8'hAA) begin
         fails++;
         $display("FAIL ok_ack: got seen=%0d %h want AA", seen, b);
      end
      tests++;
      if ({pl_if.done, pl_if.error, pl_if.busy} !== 3'b100) begin
         fails++;
         $display("FAIL ok_status: got %b want 100",
                  {pl_if.done, pl_if.error, pl_if.busy});
      end
      tests++;
      if (wq_addr.size() !== 2) begin
         fails++;
         $display("FAIL ok_wcount: got %0d want 2", wq_addr.size());
      end else begin
         tests++;
         if (wq_addr[0] !== 14'd0 || wq_data[0] !== 32'h0000_0013) begin
            fails++;
            $display("FAIL ok_word0: got %h/%h want 0000/00000013",
                     wq_addr[0], wq_data[0]);
         end
         tests++;
         if (wq_addr[1] !== 14'd1 || wq_data[1] !== 32'h00A0_0093) begin
            fails++;
            $display("FAIL ok_word1: got %h/%h want 0001/00a00093",
                     wq_addr[1], wq_data[1]);
         end
      end
   endtask

   task automatic test_bad_sum();
      bit seen;
      logic [7:0] b;
      pulse_reload();
      tests++;
      if ({pl_if.done, pl_if.busy} !== 2'b01) begin
         fails++;
         $display("FAIL reload_status: got %b want 01",
                  {pl_if.done, pl_if.busy});
      end
      wq_addr.delete();
      wq_data.delete();
      send_word(32'd2);
      send_word(32'h0000_0013);
      send_word(32'h00A0_0093);
      send_word(32'h0000_0000);
      wait_ack(seen, b);
      tests++;
      if (!seen || b !== 8'h55) begin
         fails++;
         $display("FAIL bad_ack: got seen=%0d %h want 55", seen, b);
      end
      tests++;
      if ({pl_if.done, pl_if.error, pl_if.busy} !== 3'b010) begin
         fails++;
         $display("FAIL bad_status: got %b want 010",
                  {pl_if.done, pl_if.error, pl_if.busy});
      end
      tests++;
      if (wq_addr.size() !== 2 || wq_data[1] !== 32'h00A0_0093) begin
         fails++;
         $display("FAIL bad_writes: got %0d writes want 2",
                  wq_addr.size());
      end
   endtask

   task automatic test_zero_len();
      bit seen;
      logic [7:0] b;
      pulse_reload();
      wq_addr.delete();
      wq_data.delete();
      send_word(32'd0);
      send_word(32'd0);
      wait_ack(seen, b);
      tests++;
      if (!seen || b !== 8'hAA) begin
         fails++;
         $display("FAIL zero_ack: got seen=%0d %h want AA", seen, b);
      end
      tests++;
      if (wq_addr.size() !== 0 || pl_if.done !== 1'b1) begin
         fails++;
         $display("FAIL zero_result: got writes=%0d done=%b want 0/1",
                  wq_addr.size(), pl_if.done);
      end
   endtask

   task automatic test_oversize();
      bit seen;
      logic [7:0] b;
      pulse_reload();
      wq_addr.delete();
      wq_data.delete();
      pl_if.tx_ready = 1'b0;
      send_word(32'd16385);
      tests++;
      if (pl_if.tx_valid !== 1'b1 || pl_if.tx_data !== 8'h55) begin
         fails++;
         $display("FAIL big_ack_now: got v=%b %h want 1/55",
                  pl_if.tx_valid, pl_if.tx_data);
      end
      send_word(32'h1122_3344);
      tests++;
      if (pl_if.tx_valid !== 1'b1 || wq_addr.size() !== 0) begin
         fails++;
         $display("FAIL big_ignore: got v=%b writes=%0d want 1/0",
                  pl_if.tx_valid, wq_addr.size());
      end
      pl_if.tx_ready = 1'b1;
      wait_ack(seen, b);
      tests++;
      if (!seen || b !== 8'h55 ||
          {pl_if.done, pl_if.error} !== 2'b01) begin
         fails++;
         $display("FAIL big_result: got %h d/e=%b want 55/01",
                  b, {pl_if.done, pl_if.error});
      end
   endtask

   task automatic test_ack_stall_reload();
      bit seen;
      bit stable;
      logic [7:0] b;
      pulse_reload();
      pl_if.tx_ready = 1'b0;
      send_word(32'd1);
      send_word(32'h1234_5678);
      send_word(32'h1234_5678);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (pl_if.tx_valid !== 1'b1 || pl_if.tx_data !== 8'hAA)
            stable = 1'b0;
         tick();
      end
      tests++;
      if (stable !== 1'b1 || pl_if.done !== 1'b0) begin
         fails++;
         $display("FAIL stall_hold: got stable=%0d done=%b want 1/0",
                  stable, pl_if.done);
      end
      pl_if.tx_ready = 1'b1;
      tick();
      tests++;
      if (pl_if.tx_valid !== 1'b0 || pl_if.done !== 1'b1) begin
         fails++;
         $display("FAIL stall_release: got v=%b done=%b want 0/1",
                  pl_if.tx_valid, pl_if.done);
      end
      pulse_reload();
      tests++;
      if ({pl_if.done, pl_if.busy} !== 2'b01) begin
         fails++;
         $display("FAIL reload2: got %b want 01", {pl_if.done, pl_if.busy});
      end
      wq_addr.delete();
      wq_data.delete();
      send_word(32'd2);
      send_word(32'hDEAD_BEEF);
      send_word(32'h0000_0001);
      send_word(32'hDEAD_BEEE);
      wait_ack(seen, b);
      tests++;
      if (!seen || b !== 8'hAA || wq_addr.size() !== 2) begin
         fails++;
         $display("FAIL reload_load: got %h writes=%0d want AA/2",
                  b, wq_addr.size());
      end else begin
         tests++;
         if (wq_addr[0] !== 14'd0 || wq_data[0] !== 32'hDEAD_BEEF ||
             wq_addr[1] !== 14'd1 || wq_data[1] !== 32'h0000_0001) begin
            fails++;
            $display("FAIL reload_words: got %h/%h %h/%h",
                     wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
         end
      end
   endtask

   task automatic test_mid_reset();
      bit seen;
      logic [7:0] b;
      pulse_reload();
      send_word(32'd2);
      send_byte(8'hEF);
      send_byte(8'hBE);
      send_byte(8'hAD);
      send_byte(8'hDE);
      send_byte(8'h01);
      rst = 1'b1;
      #1;
      tests++;
      if ({pl_if.busy, pl_if.done, pl_if.error, pl_if.tx_valid} !== 4'b1000 ||
          pl_if.tx_data !== 8'h00) begin
         fails++;
         $display("FAIL rst_status: got %b tx=%h want 1000/00",
                  {pl_if.busy, pl_if.done, pl_if.error, pl_if.tx_valid},
                  pl_if.tx_data);
      end
      tests++;
      if ({pl_if.imem_we, pl_if.imem_addr, pl_if.imem_wdata} !== 47'd0) begin
         fails++;
         $display("FAIL rst_imem: got we=%b a=%h d=%h want 0",
                  pl_if.imem_we, pl_if.imem_addr, pl_if.imem_wdata);
      end
      tick();
      rst = 1'b0;
      tick();
      wq_addr.delete();
      wq_data.delete();
      send_word(32'd1);
      send_word(32'hCAFE_F00D);
      send_word(32'hCAFE_F00D);
      wait_ack(seen, b);
      tests++;
      if (!seen || b !== 8'hAA || pl_if.done !== 1'b1) begin
         fails++;
         $display("FAIL rst_reload: got %h done=%b want AA/1",
                  b, pl_if.done);
      end
      tests++;
      if (wq_addr.size() !== 1 || wq_addr[0] !== 14'd0 ||
          wq_data[0] !== 32'hCAFE_F00D) begin
         fails++;
         $display("FAIL rst_word: got writes=%0d want 1 at 0 cafef00d",
                  wq_addr.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      pl_if.rx_valid = 1'b0;
      pl_if.rx_data  = 8'h00;
      pl_if.tx_ready = 1'b0;
      pl_if.reload   = 1'b0;
      tick();
      tick();
      test_reset();
      rst = 1'b0;
      tick();
      test_load_ok();
      test_bad_sum();
      test_zero_len();
      test_oversize();
      test_ack_stall_reload();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
